// File: rtl/reg_file.sv
// General-purpose register file: two combinational read ports, one synchronous write port, r0 reads zero.
// Optional write-through bypass on the read ports when RF_BYPASS_EN is defined.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [15:0]       wr_cnt
);

  localparam int unsigned DEPTH   = 2**ADDR_W;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_d;
  logic              wr_commit;

  // Writes to r0 are dropped so it never leaves its reset value.
  assign wr_commit = we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_commit) begin
      regs_d[wa] = wd;
    end
  end

  // Debug write counter sticks at all-ones rather than wrapping.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_commit && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = regs_q[ra1];
    end
`ifdef RF_BYPASS_EN
    if (wr_commit && (ra1 == wa)) begin
      rd1 = wd;
    end
`endif
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      rd2 = regs_q[ra2];
    end
`ifdef RF_BYPASS_EN
    if (wr_commit && (ra2 == wa)) begin
      rd2 = wd;
    end
`endif
  end

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the driver queues expected port values, a negedge monitor pops and compares.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic        we;
  logic [15:0] wr_cnt;

  typedef struct {
    string       name;
    int          port;   // 0=rd1 1=rd2 2=wr_cnt
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m [32];
  int          mcnt;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every queued expectation against the live outputs mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.port)
        0:       act = rd1;
        1:       act = rd2;
        default: act = {16'h0, wr_cnt};
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string name, input int port, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.port = port;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc();
    we = 1'b1; wa = a; wd = d;
    if (a != 5'd0) begin
      m[a] = d;
      mcnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    mcnt  = 0;
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd0;

    cyc();
    expect_v("reset_rd1", 0, 32'h0);
    expect_v("reset_rd2", 1, 32'h0);
    expect_v("reset_cnt", 2, 32'h0);
    cyc();
    rst_n = 1'b1;

    // Async reset wipes a written register without a clock edge.
    wr(5'd5, 32'hDEADBEEF);
    cyc();
    we = 1'b0; ra1 = 5'd5;
    expect_v("r5_written", 0, 32'hDEADBEEF);
    expect_v("cnt_before_reset", 2, 32'd1);
    cyc();
    rst_n = 1'b0;
    expect_v("r5_async_clear", 0, 32'h0);
    expect_v("cnt_async_clear", 2, 32'h0);
    m[5] = 32'h0;
    mcnt = 0;
    cyc();
    rst_n = 1'b1;
    expect_v("r5_after_release", 0, 32'h0);

    // Writes to r0 are discarded and not counted.
    wr(5'd0, 32'hFFFFFFFF);
    cyc();
    we = 1'b0; ra1 = 5'd0;
    expect_v("r0_zero", 0, 32'h0);
    expect_v("r0_cnt", 2, 32'h0);

    wr(5'd1, 32'h00000007);
    wr(5'd2, 32'hFFFFFFF9);
    cyc();
    we = 1'b0; ra1 = 5'd1; ra2 = 5'd2;
    expect_v("r1", 0, 32'h00000007);
    expect_v("r2", 1, 32'hFFFFFFF9);
    expect_v("cnt2", 2, 32'd2);

    // Read-during-write on r3.
    wr(5'd3, 32'h11111111);
    cyc();
    we = 1'b1; wa = 5'd3; wd = 32'h22222222; ra1 = 5'd3;
`ifdef RF_BYPASS_EN
    expect_v("rdw_before_edge", 0, 32'h22222222);
`else
    expect_v("rdw_before_edge", 0, 32'h11111111);
`endif
    expect_v("rdw_other_port", 1, 32'hFFFFFFF9);
    expect_v("rdw_cnt", 2, 32'd3);
    m[3] = 32'h22222222;
    mcnt++;
    cyc();
    we = 1'b0;
    expect_v("rdw_after_edge", 0, 32'h22222222);
    expect_v("rdw_cnt_after", 2, 32'd4);

    // No bypass through r0 in either build.
    cyc();
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0;
    expect_v("r0_no_bypass", 0, 32'h0);
    cyc();
    we = 1'b0;

    wr(5'd31, 32'hA5A5A5A5);
    cyc();
    we = 1'b0; ra1 = 5'd31; ra2 = 5'd31;
    expect_v("r31_p1", 0, 32'hA5A5A5A5);
    expect_v("r31_p2", 1, 32'hA5A5A5A5);
    expect_v("cnt5", 2, 32'd5);

    // 65540 back-to-back committed writes to r1..r30 drive the counter into saturation.
    for (int i = 0; i < 65540; i++) begin
      cyc();
      if (mcnt == 65534) expect_v("cnt_fffe", 2, 32'h0000FFFE);
      if (mcnt == 65535) expect_v("cnt_ffff", 2, 32'h0000FFFF);
      we = 1'b1;
      wa = 5'((i % 30) + 1);
      wd = 32'(i) * 32'd7 + 32'd1;
      m[wa] = wd;
      mcnt++;
    end
    cyc();
    we = 1'b0;
    expect_v("cnt_sat", 2, 32'h0000FFFF);
    for (int r = 1; r <= 5; r++) begin
      cyc();
      ra1 = 5'(r);
      ra2 = 5'(r + 25);
      expect_v("sat_rd1", 0, m[r]);
      expect_v("sat_rd2", 1, m[r + 25]);
    end
    cyc();
    ra1 = 5'd31;
    expect_v("r31_untouched", 0, 32'hA5A5A5A5);

    wr(5'd7, 32'hCAFEF00D);
    cyc();
    we = 1'b0; ra1 = 5'd7;
    expect_v("post_sat_write", 0, 32'hCAFEF00D);
    expect_v("cnt_holds", 2, 32'h0000FFFF);

    repeat (2) cyc();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
